// File: rtl/uart_pkg.sv
// Shared UART definitions: character width, legal frame lengths and the
// layout of one received entry.
package uart_pkg;

    localparam int UART_DATA_W  = 8;
    localparam int UART_LEN_MIN = 5;
    localparam int UART_LEN_MAX = 8;

    typedef struct packed {
        logic                   err;
        logic [UART_DATA_W-1:0] data;
    } rx_entry_t;

endpackage

// File: rtl/sync_fifo_ptr.sv
// Read/write pointers and fill level for a power-of-two circular FIFO.
// The caller only asserts push/pop when they are legal; flush wins over both.
module sync_fifo_ptr #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH),
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    output logic [AW-1:0] wr_ptr,
    output logic [AW-1:0] rd_ptr,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;

    // Pointer and fill-level state; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push) begin
                wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
                2'b01:   count_r <= count_r - {{(CW-1){1'b0}}, 1'b1};
                default: count_r <= count_r;
            endcase
        end
    end

    assign wr_ptr = wr_ptr_r;
    assign rd_ptr = rd_ptr_r;
    assign count  = count_r;
    assign full   = (count_r == CW'(DEPTH));
    assign empty  = (count_r == {CW{1'b0}});

endmodule

// File: rtl/uart_rx_buffer.sv
// Elastic receive buffer behind uart_top: edge-captures characters, masks them
// to the frame length and streams them out first-word-fall-through.
module uart_rx_buffer
    import uart_pkg::*;
#(
    parameter int DATA_W = UART_DATA_W,
    parameter int DEPTH  = 16,
    parameter int THRESH = 12
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rx_done,
    input  logic [DATA_W-1:0]          rx_out,
    input  logic                       rx_error,
    input  logic [3:0]                 length,
    input  logic                       flush,
    output logic                       m_valid,
    output logic [DATA_W-1:0]          m_data,
    output logic                       m_err,
    input  logic                       m_ready,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty,
    output logic                       overflow,
    input  logic                       ovf_clr,
    output logic [7:0]                 err_cnt,
    output logic                       irq_thresh
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic              rx_done_d_r;
    logic              overflow_r;
    logic [7:0]        err_cnt_r;
    logic [DATA_W:0]   mem_r [DEPTH];

    logic              push_req_s;
    logic              push_ok_s;
    logic              pop_s;
    logic              drop_s;
    logic [3:0]        eff_len_s;
    logic [DATA_W-1:0] masked_s;
    logic [AW-1:0]     wr_ptr_s;
    logic [AW-1:0]     rd_ptr_s;
    logic [CW-1:0]     count_s;
    logic              full_s;
    logic              empty_s;
    logic [DATA_W:0]   head_s;

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_req_s = rx_done & ~rx_done_d_r;
    assign pop_s      = ~empty_s & m_ready;
    assign push_ok_s  = push_req_s & ~flush & (~full_s | pop_s);
    assign drop_s     = push_req_s & ~flush & full_s & ~pop_s;

    // Clamp illegal frame lengths to the full width, then zero the unused MSBs.
    always_comb begin
        eff_len_s = 4'(UART_LEN_MAX);
        masked_s  = {DATA_W{1'b0}};
        if ((length >= 4'(UART_LEN_MIN)) && (length <= 4'(UART_LEN_MAX))) begin
            eff_len_s = length;
        end else begin
            eff_len_s = 4'(UART_LEN_MAX);
        end
        for (int i = 0; i < DATA_W; i++) begin
            masked_s[i] = (i < int'(eff_len_s)) ? rx_out[i] : 1'b0;
        end
    end

    sync_fifo_ptr #(
        .DEPTH (DEPTH)
    ) u_ptr (
        .clk    (clk),
        .rst    (rst),
        .push   (push_ok_s),
        .pop    (pop_s),
        .flush  (flush),
        .wr_ptr (wr_ptr_s),
        .rd_ptr (rd_ptr_s),
        .count  (count_s),
        .full   (full_s),
        .empty  (empty_s)
    );

    // Storage array; contents are only observable through a valid head.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_s] <= {rx_error, masked_s};
        end
    end

    // Edge detector, sticky overflow and saturating error counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_done_d_r <= 1'b0;
            overflow_r  <= 1'b0;
            err_cnt_r   <= 8'd0;
        end else begin
            rx_done_d_r <= rx_done;
            if (drop_s) begin
                overflow_r <= 1'b1;
            end else if (ovf_clr) begin
                overflow_r <= 1'b0;
            end
            if (push_req_s && rx_error && (err_cnt_r != 8'hFF)) begin
                err_cnt_r <= err_cnt_r + 8'd1;
            end
        end
    end

    assign head_s     = mem_r[rd_ptr_s];
    assign m_valid    = ~empty_s;
    assign m_data     = m_valid ? head_s[DATA_W-1:0] : {DATA_W{1'b0}};
    assign m_err      = m_valid ? head_s[DATA_W] : 1'b0;
    assign count      = count_s;
    assign full       = full_s;
    assign empty      = empty_s;
    assign overflow   = overflow_r;
    assign err_cnt    = err_cnt_r;
    assign irq_thresh = (count_s >= CW'(THRESH));

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Scoreboard bench for uart_rx_buffer: expected entries are queued as
// characters are driven and compared against the stream head as it drains.
module tb_uart_rx_buffer;

    logic       clk;
    logic       rst;
    logic       rx_done;
    logic [7:0] rx_out;
    logic       rx_error;
    logic [3:0] length;
    logic       flush;
    logic       m_valid;
    logic [7:0] m_data;
    logic       m_err;
    logic       m_ready;
    logic [4:0] count;
    logic       full;
    logic       empty;
    logic       overflow;
    logic       ovf_clr;
    logic [7:0] err_cnt;
    logic       irq_thresh;

    int total = 0;
    int bad   = 0;

    logic [8:0] sb[$];
    logic       exp_ovf;
    int         exp_errs;

    uart_rx_buffer #(.DATA_W(8), .DEPTH(16), .THRESH(12)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_done    (rx_done),
        .rx_out     (rx_out),
        .rx_error   (rx_error),
        .length     (length),
        .flush      (flush),
        .m_valid    (m_valid),
        .m_data     (m_data),
        .m_err      (m_err),
        .m_ready    (m_ready),
        .count      (count),
        .full       (full),
        .empty      (empty),
        .overflow   (overflow),
        .ovf_clr    (ovf_clr),
        .err_cnt    (err_cnt),
        .irq_thresh (irq_thresh)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] mask_exp(input logic [7:0] d, input logic [3:0] len);
        case (len)
            4'd5:    return d & 8'h1F;
            4'd6:    return d & 8'h3F;
            4'd7:    return d & 8'h7F;
            default: return d;
        endcase
    endfunction

    task automatic check_status(input string tag);
        check_eq({tag, ".count"}, 32'(count), 32'(sb.size()));
        check_eq({tag, ".full"}, 32'(full), 32'(sb.size() == 16));
        check_eq({tag, ".empty"}, 32'(empty), 32'(sb.size() == 0));
        check_eq({tag, ".valid"}, 32'(m_valid), 32'(sb.size() != 0));
        check_eq({tag, ".irq"}, 32'(irq_thresh), 32'(sb.size() >= 12));
        check_eq({tag, ".ovf"}, 32'(overflow), 32'(exp_ovf));
        check_eq({tag, ".errcnt"}, 32'(err_cnt), 32'(exp_errs));
        if (sb.size() != 0) begin
            check_eq({tag, ".head"}, {23'd0, m_err, m_data}, {23'd0, sb[0]});
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, ".count"}, 32'(count), 32'd0);
        check_eq({tag, ".empty"}, 32'(empty), 32'd1);
        check_eq({tag, ".full"}, 32'(full), 32'd0);
        check_eq({tag, ".valid"}, 32'(m_valid), 32'd0);
        check_eq({tag, ".data"}, 32'(m_data), 32'd0);
        check_eq({tag, ".err"}, 32'(m_err), 32'd0);
        check_eq({tag, ".ovf"}, 32'(overflow), 32'd0);
        check_eq({tag, ".errcnt"}, 32'(err_cnt), 32'd0);
        check_eq({tag, ".irq"}, 32'(irq_thresh), 32'd0);
    endtask

    // One operation: strobes held for one cycle, then one idle cycle.
    task automatic drive_op(input string tag, input logic do_push, input logic [7:0] d,
                            input logic e, input logic [3:0] len, input logic rdy,
                            input logic clr, input logic fl);
        logic did_pop;
        @(negedge clk);
        did_pop = 1'b0;
        if (rdy && sb.size() != 0 && !fl) begin
            check_eq({tag, ".pre_valid"}, 32'(m_valid), 32'd1);
            check_eq({tag, ".pop_head"}, {23'd0, m_err, m_data}, {23'd0, sb[0]});
            did_pop = 1'b1;
        end
        rx_done  = do_push;
        rx_out   = d;
        rx_error = e;
        length   = len;
        m_ready  = rdy;
        ovf_clr  = clr;
        flush    = fl;
        @(negedge clk);
        rx_done = 1'b0;
        m_ready = 1'b0;
        ovf_clr = 1'b0;
        flush   = 1'b0;
        if (do_push && e && exp_errs < 255) exp_errs++;
        if (fl) begin
            sb.delete();
        end else begin
            if (did_pop) void'(sb.pop_front());
            if (do_push) begin
                if (sb.size() < 16) sb.push_back({e, mask_exp(d, len)});
                else exp_ovf = 1'b1;
            end else if (clr) begin
                exp_ovf = 1'b0;
            end
            if (do_push && clr && sb.size() < 16) exp_ovf = 1'b0;
        end
        check_status(tag);
    endtask

    initial begin
        rst = 1'b1; rx_done = 1'b0; rx_out = 8'h00; rx_error = 1'b0;
        length = 4'd8; flush = 1'b0; m_ready = 1'b0; ovf_clr = 1'b0;
        exp_ovf = 1'b0; exp_errs = 0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        drive_op("cap_aa", 1'b1, 8'hAA, 1'b0, 4'd8, 1'b0, 1'b0, 1'b0);
        drive_op("pop_aa", 1'b0, 8'h00, 1'b0, 4'd8, 1'b1, 1'b0, 1'b0);

        drive_op("len6", 1'b1, 8'hEA, 1'b0, 4'd6, 1'b0, 1'b0, 1'b0);
        check_eq("len6.data", 32'(m_data), 32'h2A);
        drive_op("pop6", 1'b0, 8'h00, 1'b0, 4'd8, 1'b1, 1'b0, 1'b0);
        drive_op("len5", 1'b1, 8'hD6, 1'b0, 4'd5, 1'b0, 1'b0, 1'b0);
        check_eq("len5.data", 32'(m_data), 32'h16);
        drive_op("pop5", 1'b0, 8'h00, 1'b0, 4'd8, 1'b1, 1'b0, 1'b0);
        drive_op("len9", 1'b1, 8'hFE, 1'b0, 4'd9, 1'b0, 1'b0, 1'b0);
        check_eq("len9.data", 32'(m_data), 32'hFE);
        drive_op("pop9", 1'b0, 8'h00, 1'b0, 4'd8, 1'b1, 1'b0, 1'b0);

        // Long rx_done pulse must yield a single entry.
        @(negedge clk);
        rx_out = 8'h55; length = 4'd8; rx_error = 1'b0; rx_done = 1'b1;
        repeat (10) @(negedge clk);
        rx_done = 1'b0;
        sb.push_back({1'b0, 8'h55});
        @(negedge clk);
        check_status("hold");
        drive_op("pop_hold", 1'b0, 8'h00, 1'b0, 4'd8, 1'b1, 1'b0, 1'b0);

        for (int i = 0; i < 17; i++) begin
            drive_op($sformatf("fill%0d", i), 1'b1, 8'(i), 1'b0, 4'd8, 1'b0, 1'b0, 1'b0);
        end
        drive_op("clr", 1'b0, 8'h00, 1'b0, 4'd8, 1'b0, 1'b1, 1'b0);
        drive_op("full_pushpop", 1'b1, 8'h77, 1'b0, 4'd8, 1'b1, 1'b0, 1'b0);
        drive_op("clr_vs_drop", 1'b1, 8'h88, 1'b0, 4'd8, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) begin
            drive_op($sformatf("drain%0d", i), 1'b0, 8'h00, 1'b0, 4'd8, 1'b1, 1'b0, 1'b0);
        end

        for (int i = 0; i < 3; i++) begin
            drive_op($sformatf("errcap%0d", i), 1'b1, 8'(8'hC0 + i), 1'b1, 4'd8, 1'b0, 1'b0, 1'b0);
        end
        check_eq("errcnt3", 32'(err_cnt), 32'd3);
        for (int i = 0; i < 3; i++) begin
            drive_op($sformatf("errpop%0d", i), 1'b0, 8'h00, 1'b0, 4'd8, 1'b1, 1'b0, 1'b0);
        end

        for (int i = 0; i < 5; i++) begin
            drive_op($sformatf("pre_flush%0d", i), 1'b1, 8'(8'h30 + i), 1'b0, 4'd7, 1'b0, 1'b0, 1'b0);
        end
        drive_op("flush", 1'b0, 8'h00, 1'b0, 4'd8, 1'b0, 1'b0, 1'b1);

        for (int i = 0; i < 3; i++) begin
            drive_op($sformatf("burst%0d", i), 1'b1, 8'(8'h60 + i), 1'b1, 4'd8, 1'b0, 1'b0, 1'b0);
        end
        // Reset mid-cycle with a capture in flight; outputs must clear at once.
        @(negedge clk);
        rx_done = 1'b1; rx_out = 8'h3C; rx_error = 1'b0; length = 4'd8;
        #2 rst = 1'b1;
        #1 check_reset_outputs("async_rst");
        sb.delete(); exp_ovf = 1'b0; exp_errs = 0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rx_done = 1'b0;
        sb.push_back({1'b0, 8'h3C});
        check_status("rst_edge_cap");
        drive_op("pop_final", 1'b0, 8'h00, 1'b0, 4'd8, 1'b1, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_buffer.md
Name: uart_rx_buffer

Overview:
- Receive-side elastic buffer directly downstream of uart_top.
- Captures each received character (rx_out, rx_error) on the rising edge of rx_done and masks it to the active frame length.
- Queues characters in a circular FIFO and presents them on a valid/ready stream for the host or a UVM consumer.
- Tracks overflow, error count and a fill-threshold interrupt.

Parameters:
DATA_W, 8, character width; equals the widest uart_top frame.
DEPTH, 16, FIFO entries; power of two, minimum 2.
THRESH, 12, fill level at which irq_thresh asserts; range 1..DEPTH.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
rx_done  in  1  from uart_top; may stay high for many cycles
rx_out  in  DATA_W  received character from uart_top
rx_error  in  1  parity/stop error for the current character
length  in  4  active frame length 5..8; same value driven to uart_top
flush  in  1  synchronous FIFO clear
m_valid  out  1  head entry available
m_data  out  DATA_W  head character, length-masked
m_err  out  1  error tag of the head entry
m_ready  in  1  consumer accepts head
count  out  $clog2(DEPTH)+1  current fill level
full  out  1  count == DEPTH
empty  out  1  count == 0
overflow  out  1  sticky: a character was dropped
ovf_clr  in  1  clears overflow
err_cnt  out  8  saturating count of captured characters with rx_error=1
irq_thresh  out  1  count >= THRESH

Behaviour:
- Reset (async, rst=1): pointers=0; count=0; empty=1; full=0; m_valid=0; m_data=0; m_err=0; overflow=0; err_cnt=0; irq_thresh=0; rx_done_d=0.
- Capture: rx_done_d registers rx_done. Push request = rx_done & ~rx_done_d, so one push per rx_done rising edge regardless of pulse width.
- Capture also occurs when rx_done is already high as rst deasserts; rx_done_d resets to 0, so that edge is treated as a rising edge.
- Masking: bits [DATA_W-1:length] are forced to 0 before the write.
- length outside 5..8 is treated as 8.
- The entry stored is {rx_error, masked data}.
- Latency: push sampled at posedge N. The entry is written at N, and m_valid rises after N if the FIFO was empty. There is 1 cycle from the sampled rx_done edge to m_valid.
- Read: first-word fall-through. m_data and m_err are driven from the head entry. A pop occurs when m_valid & m_ready at a posedge. m_data, m_err and m_valid are driven only while m_valid=1, and m_ready is ignored while m_valid=0.
- Pointers: DEPTH-wide wrap-around with no special case at the index DEPTH-1 to 0 transition.
- count updates as follows: +1 on push only, -1 on pop only, unchanged on push+pop.
- When full:
  - A push without a simultaneous pop is dropped and sets overflow=1; FIFO contents are unchanged.
  - Push and pop in the same cycle: both are accepted, count stays DEPTH, and overflow is not set.
- When empty: a pop cannot occur because m_valid=0. A push in the same cycle is accepted normally.
- err_cnt increments on every accepted or dropped capture with rx_error=1, and saturates at 255.
- err_cnt clears only on rst.
- overflow is sticky until ovf_clr. If ovf_clr and a new drop occur in the same cycle, the set wins.
- Flush priority: flush=1 at a posedge zeroes pointers and count and overrides push/pop in that cycle; the push is discarded.
- flush does not clear overflow or err_cnt.
- irq_thresh is a combinational compare on the registered count.
- Reset mid-operation discards all queued entries immediately (async). No stream output glitches beyond the m_valid drop.

Decomposition:
- Shared package uart_pkg holds: UART_DATA_W=8, UART_LEN_MIN=5, UART_LEN_MAX=8, and the typedef rx_entry_t (struct: err bit, data[UART_DATA_W-1:0]).
- Sub-module sync_fifo_ptr is the natural split: it contains the pointer/count/full/empty logic with push/pop/flush inputs.
- uart_rx_buffer keeps capture, masking, storage array, sticky flags and counters.

Test Plan:
- length=8, rx_out=0xAA, rx_done pulse → after 1 cycle m_valid=1, m_data=0xAA, m_err=0, count=1; m_ready=1 → empty=1.
- length=6, rx_out=0xEA → m_data=0x2A. length=5, rx_out=0xD6 → m_data=0x16. length=9, rx_out=0xFE → m_data=0xFE.
- rx_done held high 10 cycles with rx_out=0x55 → exactly one entry, count=1.
- 17 captures 0x00..0x10 with m_ready=0 → full=1 and irq_thresh=1 from count 12 onward; overflow=1; then reading yields 0x00..0x0F in order, and 0x10 is absent.
- With the FIFO full, a capture in the same cycle as a pop → count stays 16 and overflow stays 0. A later ovf_clr with a simultaneous drop → overflow=1.
- Three captures with rx_error=1 → m_err=1 on each, err_cnt=3.
- flush with 5 entries → empty=1 next cycle, and err_cnt is unchanged.
- rst asserted mid-burst → all outputs at reset values immediately.
